ofifo_drain_ctrl: RTL
=====================

# ofifo_drain_ctrl

Read-side controller that drains a bank of `col` depth-8 output FIFOs (one per array column) into the output SRAM. Runs entirely in the FIFO read clock domain, issues per-FIFO `rd` strobes, captures FIFO head data, and produces registered SRAM write commands with an auto-incrementing address. It supports two modes:
- **Lockstep:** one full row across all columns per write.
- **Round-robin:** one word from one column per write.

## Interface
Parameters:
- `col`, 8, number of FIFOs / columns
- `bw`, 16, data width per FIFO
- `addr_w`, 11, SRAM address width

Ports:
- `rd_clk`  in  1  clock; also the read clock of every drained FIFO
- `reset`  in  1  synchronous, active-high
- `i_start`  in  1  start pulse; sampled only in IDLE
- `i_mode`  in  1  0 = round-robin, 1 = lockstep; latched on accepted start
- `i_base_addr`  in  addr_w  first SRAM address; latched on start
- `i_count`  in  addr_w+1  number of writes to perform; latched on start
- `i_stall`  in  1  SRAM backpressure; while high, no new `rd` is issued
- `i_empty`  in  col  per-FIFO `o_empty` flags
- `i_data`  in  col*bw  per-FIFO `out` buses; lane k = bits [k*bw +: bw]
- `o_rd`  out  col  per-FIFO read strobes
- `o_wen`  out  1  SRAM write enable
- `o_waddr`  out  addr_w  SRAM write address
- `o_wdata`  out  col*bw  write data; in round-robin mode only lane 0 is meaningful, upper lanes are 0
- `o_wch`  out  $clog2(col)  source channel of the write (round-robin); 0 in lockstep
- `o_busy`  out  1  high in DRAIN
- `o_done`  out  1  one-cycle completion pulse

## Operation
- **FSM states:** IDLE, DRAIN, DONE.
- **IDLE:**
  - `i_start` = 1 with `i_count` != 0 → DRAIN.
  - `i_start` = 1 with `i_count` == 0 → DONE.
  - Start, mode, base address and count are latched. The remaining-count register is loaded with `i_count`, the write address with `i_base_addr`, and the round-robin pointer with 0.
- **DRAIN, lockstep:**
  - Issue condition: `&~i_empty && !i_stall && remaining != 0`.
  - On issue, `o_rd` = all ones for one cycle, all lanes of `i_data` are captured, and remaining decrements by 1.
- **DRAIN, round-robin:**
  - Grant goes to the first channel k with `!i_empty[k]`, searching from the pointer upward with wrap at `col`.
  - On grant, with `!i_stall` and remaining != 0: `o_rd` is one-hot at k, lane k is captured into `o_wdata[bw-1:0]`, `o_wch` = k, pointer = (k+1) mod `col`, and remaining decrements.
  - No non-empty channel → no issue; the pointer holds.
- **Leaving DRAIN:** the cycle after the final issue (remaining reaches 0), DRAIN → DONE.
- **DONE:** `o_done` = 1 for exactly one cycle, then → IDLE.
- **Ignored inputs:**
  - `i_start` in DRAIN or DONE is ignored.
  - `i_empty` and `i_data` are don't-care outside DRAIN.
- **Address arithmetic:** `o_waddr` increments by 1 per write, modulo 2^`addr_w`; wrap from all ones to 0 is legal and silent.
- **`o_rd` guarantees:** never asserted to an empty FIFO, and never asserted outside DRAIN.
- **Reset:** takes effect in any state. It forces IDLE and drops all outputs to 0 on the next edge. FIFO contents are not flushed by this block.

## Timing
- Reset values: `o_rd` = 0, `o_wen` = 0, `o_waddr` = 0, `o_wdata` = 0, `o_wch` = 0, `o_busy` = 0, `o_done` = 0.
- **Start latency:** accepted start at edge t puts the FSM in DRAIN from t+1; the first `o_rd` can assert in cycle t+1.
- **Read and write timing:**
  - `o_rd` is combinational from registered state plus `i_empty` / `i_stall`.
  - FIFO head data is combinational from its `rd_ptr`, so data is captured at the same edge that advances the FIFO pointer.
  - `o_wen`, `o_waddr`, `o_wdata` and `o_wch` are registered and assert the cycle after the corresponding `o_rd` (1-cycle latency).
  - The first write uses `i_base_addr`.
- **Throughput:** one write per cycle sustained while data is available and `i_stall` = 0.
- **Stall:** `i_stall` blocks issue in the same cycle. A write already registered still completes; there is no write-side hold.
- **Completion:** `o_done` asserts in the cycle after the last `o_wen`; `o_busy` falls in that same cycle.
- **Simultaneous events:** `i_stall` high at the same time as the last FIFO becoming non-empty → no issue that cycle.

## Structure
- **Shared package `ofifo_ctrl_pkg`:**
  - FSM state encoding (IDLE = 2'd0, DRAIN = 2'd1, DONE = 2'd2).
  - Mode constants MODE_RR = 1'b0, MODE_LOCK = 1'b1.
- **Sub-module `rr_arbiter`:** parameterized by `col`. Inputs are the request vector (~`i_empty`) and the pointer; outputs are a one-hot grant, the granted index and a `valid` flag. Purely combinational.
- Everything else (FSM, counters, capture registers) lives in `ofifo_drain_ctrl`.

## Test plan
- **Lockstep basic:**
  - Stimulus: col = 8, all FIFOs preloaded with 3 rows, start mode = 1, base = 0x10, count = 3.
  - Required response: `o_rd` = 8'hFF for 3 consecutive cycles; `o_wen` at addresses 0x10, 0x11, 0x12 with matching rows; `o_done` one cycle after the last write; all FIFOs empty.
- **Lockstep gap:**
  - Stimulus: FIFO 5 empty for 4 cycles mid-drain.
  - Required response: no `o_rd`, no `o_wen` during the gap; resumes with contiguous addresses.
- **Round-robin fairness:**
  - Stimulus: FIFOs 1, 3 and 6 each hold 2 words; count = 6.
  - Required response: grant order 1, 3, 6, 1, 3, 6; `o_wch` matches; `o_rd` is always one-hot.
- **Stall, then address wrap:**
  - Stimulus: base = 2^`addr_w`−1, count = 2, `i_stall` high for 3 cycles after start.
  - Required response: no `o_rd` while stalled; then writes at addresses 0x7FF and 0x000.
- **count = 0 and ignored restart:**
  - Stimulus: start with count = 0.
  - Required response: `o_done` at t+1 and zero `o_rd`.
  - Stimulus: a second `i_start` during DRAIN.
  - Required response: the start is ignored; the latched count is unchanged.
- **Reset mid-drain:**
  - Stimulus: assert reset after 2 of 5 writes.
  - Required response: next cycle all outputs are 0 and the FSM is IDLE; a fresh start drains the remaining FIFO data correctly.

Source files
------------

// File: rtl/ofifo_ctrl_pkg.sv
// Shared definitions for the output-FIFO drain controller: FSM state
// encoding and drain mode constants.
package ofifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_LOCK = 1'b1;

endpackage

// File: rtl/ofifo_drain_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel
// at or above the pointer, wrapping at col.
module rr_arbiter #(
  parameter int col = 8
) (
  input  logic [col-1:0]         req,
  input  logic [$clog2(col)-1:0] ptr,
  output logic [col-1:0]         grant,
  output logic [$clog2(col)-1:0] grant_idx,
  output logic                   valid
);

  localparam int idx_w = $clog2(col);

  logic [idx_w-1:0] cand;

  // Walk the channels starting at the pointer and grant the first requester
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int i = 0; i < col; i++) begin
      cand = idx_w'((int'(ptr) + i) % col);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ofifo_drain_ctrl.sv
// Read-side drain controller for a bank of column output FIFOs. Issues
// read strobes, captures FIFO head data and produces registered SRAM write
// commands with an auto-incrementing address, in lockstep or round-robin.
module ofifo_drain_ctrl #(
  parameter int col    = 8,
  parameter int bw     = 16,
  parameter int addr_w = 11
) (
  input  logic                   rd_clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic                   i_mode,
  input  logic [addr_w-1:0]      i_base_addr,
  input  logic [addr_w:0]        i_count,
  input  logic                   i_stall,
  input  logic [col-1:0]         i_empty,
  input  logic [col*bw-1:0]      i_data,
  output logic [col-1:0]         o_rd,
  output logic                   o_wen,
  output logic [addr_w-1:0]      o_waddr,
  output logic [col*bw-1:0]      o_wdata,
  output logic [$clog2(col)-1:0] o_wch,
  output logic                   o_busy,
  output logic                   o_done
);

  import ofifo_ctrl_pkg::*;

  localparam int ch_w = $clog2(col);

  drain_state_t      state_q;
  drain_state_t      state_d;
  logic              mode_q;
  logic [addr_w:0]   remaining_q;
  logic [addr_w-1:0] addr_q;
  logic [ch_w-1:0]   ptr_q;
  logic [ch_w-1:0]   ptr_next;

  logic [col-1:0]    grant;
  logic [ch_w-1:0]   grant_idx;
  logic              grant_valid;
  logic              issue;
  logic [col-1:0]    rd;
  logic [bw-1:0]     rr_lane;
  logic [col*bw-1:0] wdata_d;

  rr_arbiter #(.col(col)) u_arb (
    .req       (~i_empty),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  assign rr_lane  = i_data[int'(grant_idx)*bw +: bw];
  assign ptr_next = (grant_idx == ch_w'(col - 1)) ? '0 : grant_idx + 1'b1;

  // Next-state logic and read issue; a read only fires in DRAIN with work left
  always_comb begin
    state_d = state_q;
    rd      = '0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = (i_count == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (!i_stall) begin
          if (mode_q == MODE_LOCK) begin
            if (&(~i_empty)) begin
              rd    = '1;
              issue = 1'b1;
            end
          end else if (grant_valid) begin
            rd    = grant;
            issue = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Select the write payload: a full row in lockstep, one lane in round-robin
  always_comb begin
    wdata_d = '0;
    if (mode_q == MODE_LOCK) begin
      wdata_d = i_data;
    end else begin
      wdata_d[bw-1:0] = rr_lane;
    end
  end

  // FSM state register
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job registers: latched on an accepted start, advanced on every issue
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      mode_q      <= MODE_RR;
      remaining_q <= '0;
      addr_q      <= '0;
      ptr_q       <= '0;
    end else if (state_q == IDLE && i_start) begin
      mode_q      <= i_mode;
      remaining_q <= i_count;
      addr_q      <= i_base_addr;
      ptr_q       <= '0;
    end else if (issue) begin
      remaining_q <= remaining_q - 1'b1;
      addr_q      <= addr_q + 1'b1;
      if (mode_q == MODE_RR) begin
        ptr_q <= ptr_next;
      end
    end
  end

  // SRAM write command registers, one cycle behind the matching read strobe
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_wch   <= '0;
    end else begin
      o_wen <= issue;
      if (issue) begin
        o_waddr <= addr_q;
        o_wdata <= wdata_d;
        o_wch   <= (mode_q == MODE_LOCK) ? '0 : grant_idx;
      end
    end
  end

  assign o_rd   = rd;
  assign o_busy = (state_q == DRAIN);
  assign o_done = (state_q == DONE);

endmodule
